fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameters: DBITS, default 32, datapath/address width; START_PC, default 32'h40, fetch PC after reset; DEPTH, default 4, fetch-queue entries (power of 2, >=2); PC_INC, default 4, sequential PC increment.
REQ-002 Ports: clk  input  1  sole clock, all state rising-edge.
REQ-003 res  input  1  asynchronous active-high reset.
REQ-004 redirect  input  1  taken branch/jump; load redirect_pc and flush.
REQ-005 redirect_pc  input  DBITS  redirect target address.
REQ-006 imem_req  output  1  instruction-memory read request this cycle.
REQ-007 imem_addr  output  DBITS  request address (current fetch PC).
REQ-008 imem_rdata  input  DBITS  read data; valid exactly one cycle after an accepted imem_req.
REQ-009 out_valid  output  1  queue head holds a valid instruction.
REQ-010 out_ready  input  1  decode accepts head this cycle.
REQ-011 out_instr  output  DBITS  head instruction word.
REQ-012 out_pc  output  DBITS  PC of head instruction.
REQ-013 pc_out  output  DBITS  current fetch PC (value of the fetch PC register).
REQ-014 count  output  clog2(DEPTH+1)  occupied queue entries.

Function
REQ-015 The fetch PC register (fpc) drives imem_addr and pc_out at all times.
REQ-016 inflight = 1 in the cycle after imem_req was high, else 0.
REQ-017 imem_req = !redirect && (count + inflight < DEPTH); combinational, no dependence on out_ready.
REQ-018 On a clock edge with imem_req high: fpc <= fpc + PC_INC, modulo 2^DBITS (0xFFFFFFFC + 4 -> 0x0).
REQ-019 On a clock edge with imem_req low and redirect low: fpc holds.
REQ-020 Response capture: when inflight=1 and not killed, {imem_rdata, PC of that request} pushed at queue tail on that cycle's edge.
REQ-021 Queue is FIFO with wrapping head/tail pointers; issue rule of REQ-017 guarantees no overflow; push into a full queue never occurs.
REQ-022 out_valid = (count != 0); out_instr/out_pc show head entry; both 0 when count == 0.
REQ-023 Pop when out_valid && out_ready; head advances one entry per cycle max.
REQ-024 Simultaneous push and pop: count unchanged, both take effect; with count == 0 a push is visible on out_valid the following cycle (no bypass).
REQ-025 Redirect cycle edge: fpc <= redirect_pc; queue flushed (count <= 0, pointers reset); any response arriving in the cycle after a redirect (request issued before redirect) is killed and not pushed.
REQ-026 A pop handshake in the same cycle as redirect counts as consumed; entry is removed by the flush regardless.
REQ-027 Redirect held high multiple cycles: imem_req stays 0, fpc reloads redirect_pc every cycle, queue stays empty.
REQ-028 Latency: request at cycle N -> entry visible on out_valid at cycle N+2; steady-state throughput one instruction per cycle with out_ready high.

Reset
REQ-029 Asserting res immediately, without a clock edge: fpc = START_PC, count = 0, inflight = 0, kill = 0, out_valid = 0, out_instr = out_pc = 0.
REQ-030 While res is high imem_req = 0; first request (address START_PC) in the first cycle after res deasserts.
REQ-031 Response to a request issued before reset is never pushed.

Verification
REQ-032 Reset release, DEPTH=4, out_ready=1, memory returns data = addr ^ 0xA5A5A5A5 -> req addrs 0x40,0x44,0x48...; out_pc 0x40 two cycles after first req, then 0x44, 0x48 on consecutive cycles.
REQ-033 out_ready=0 from start -> exactly 4 requests (0x40..0x4C), then imem_req=0, count=4, pc_out=0x50; out_ready=1 -> pop 0x40, requests resume at 0x50 with no entry lost or duplicated.
REQ-034 redirect=1, redirect_pc=0x100 while request 0x48 in flight and queue holds 2 -> next cycle count=0, response for 0x48 dropped, next req 0x100, next out_pc 0x100.
REQ-035 redirect_pc=0xFFFFFFFC -> requests 0xFFFFFFFC then 0x00000000; out_pc follows same order.
REQ-036 res asserted mid-stream between clock edges with count=3 -> count=0, pc_out=0x40, out_valid=0 before next edge; deassert -> first req 0x40.
REQ-037 Queue full, out_ready=1 continuously -> push and pop every cycle, count stays at steady value, imem_req high every cycle, order preserved.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues sequential instruction-memory reads and
// buffers returned words with their PCs in a small FIFO feeding decode.
module fetch_unit #(
    parameter int unsigned      DBITS    = 32,
    parameter logic [DBITS-1:0] START_PC = 'h40,
    parameter int unsigned      DEPTH    = 4,
    parameter int unsigned      PC_INC   = 4
) (
    input  logic                         clk,
    input  logic                         res,
    input  logic                         redirect,
    input  logic [DBITS-1:0]             redirect_pc,
    output logic                         imem_req,
    output logic [DBITS-1:0]             imem_addr,
    input  logic [DBITS-1:0]             imem_rdata,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DBITS-1:0]             out_instr,
    output logic [DBITS-1:0]             out_pc,
    output logic [DBITS-1:0]             pc_out,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTRW = $clog2(DEPTH);
    localparam int CNTW = $clog2(DEPTH + 1);

    logic [DBITS-1:0] fpc_q, fpc_d;
    logic [DBITS-1:0] req_pc_q, req_pc_d;
    logic             inflight_q, inflight_d;
    logic             kill_q, kill_d;
    logic [PTRW-1:0]  head_q, head_d;
    logic [PTRW-1:0]  tail_q, tail_d;
    logic [CNTW-1:0]  count_q, count_d;

    logic [DBITS-1:0] instr_mem_q [DEPTH];
    logic [DBITS-1:0] pc_mem_q    [DEPTH];

    logic push;
    logic pop;

    // Reserving a slot for the in-flight response is what makes overflow impossible.
    assign imem_req  = !res && !redirect &&
                       ((32'(count_q) + 32'(inflight_q)) < DEPTH);
    assign imem_addr = fpc_q;
    assign pc_out    = fpc_q;
    assign count     = count_q;

    assign out_valid = (count_q != '0);
    assign out_instr = out_valid ? instr_mem_q[head_q] : '0;
    assign out_pc    = out_valid ? pc_mem_q[head_q]    : '0;

    // A response landing on a redirect edge, or flagged stale, is dropped.
    assign push = inflight_q && !kill_q && !redirect;
    assign pop  = out_valid && out_ready;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        fpc_d      = fpc_q;
        req_pc_d   = req_pc_q;
        inflight_d = imem_req;
        kill_d     = redirect;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;

        if (imem_req) begin
            fpc_d    = fpc_q + DBITS'(PC_INC);
            req_pc_d = fpc_q;
        end

        if (redirect) begin
            fpc_d   = redirect_pc;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) tail_d = tail_q + PTRW'(1);
            if (pop)  head_d = head_q + PTRW'(1);
            count_d = count_q + CNTW'(push) - CNTW'(pop);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            fpc_q      <= START_PC;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
            kill_q     <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            fpc_q      <= fpc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
            kill_q     <= kill_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

    // NOTE: queue storage is not reset; count gates visibility, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem_q[tail_q] <= imem_rdata;
            pc_mem_q[tail_q]    <= req_pc_q;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random traffic,
// all compared against a queue-based reference model of the fetch pipeline.
module tb_fetch_unit;

    localparam int          DEPTH = 4;
    localparam logic [31:0] KEY   = 32'hA5A5A5A5;

    logic        clk = 1'b0;
    logic        res = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] pc_out;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_unit #(
        .DBITS    (32),
        .START_PC (32'h40),
        .DEPTH    (DEPTH),
        .PC_INC   (4)
    ) dut (
        .clk         (clk),
        .res         (res),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .pc_out      (pc_out),
        .count       (count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Instruction memory: data = addr ^ KEY one cycle after an accepted request,
    // garbage otherwise so a spurious capture shows up.
    logic        pend_req = 1'b0;
    logic [31:0] pend_addr = '0;
    always @(negedge clk) begin
        pend_req  = imem_req;
        pend_addr = imem_addr;
    end
    always @(posedge clk) begin
        #1;
        imem_rdata = pend_req ? (pend_addr ^ KEY) : 32'($urandom);
    end

    // Reference model: fetch PC, one optional outstanding request, FIFO of PCs.
    logic [31:0] m_q[$];
    logic [31:0] m_fpc = 32'h40;
    bit          m_infl = 1'b0;
    logic [31:0] m_infl_pc = '0;
    int          req_seen = 0;

    always @(negedge clk) begin
        bit          exp_req;
        logic [31:0] head;
        if (res) begin
            m_q.delete();
            m_fpc    = 32'h40;
            m_infl   = 1'b0;
            req_seen = 0;
            check("rst_req", 32'(imem_req), 32'd0);
            check("rst_count", 32'(count), 32'd0);
        end else begin
            exp_req = !redirect && ((m_q.size() + int'(m_infl)) < DEPTH);
            head    = (m_q.size() != 0) ? m_q[0] : 32'd0;
            check("m_req", 32'(imem_req), 32'(exp_req));
            check("m_pc", pc_out, m_fpc);
            check("m_count", 32'(count), 32'(m_q.size()));
            check("m_valid", 32'(out_valid), 32'(m_q.size() != 0));
            check("m_out_pc", out_pc, head);
            check("m_out_instr", out_instr, (m_q.size() != 0) ? (head ^ KEY) : 32'd0);
            if (exp_req) req_seen++;
            if (redirect) begin
                m_q.delete();
                m_fpc  = redirect_pc;
                m_infl = 1'b0;
            end else begin
                if (m_q.size() != 0 && out_ready) void'(m_q.pop_front());
                if (m_infl) m_q.push_back(m_infl_pc);
                m_infl = exp_req;
                if (exp_req) begin
                    m_infl_pc = m_fpc;
                    m_fpc     = m_fpc + 32'd4;
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset(input bit rdy);
        next_cycle();
        res       = 1'b1;
        redirect  = 1'b0;
        out_ready = rdy;
        next_cycle();
        res = 1'b0;
    endtask

    initial begin
        logic [31:0] rnd;

        // Asynchronous reset takes effect with no clock edge.
        #1 res = 1'b1;
        #1;
        check("rst0_count", 32'(count), 32'd0);
        check("rst0_valid", 32'(out_valid), 32'd0);
        check("rst0_out_pc", out_pc, 32'd0);
        check("rst0_out_instr", out_instr, 32'd0);
        check("rst0_pc_out", pc_out, 32'h40);
        check("rst0_req", 32'(imem_req), 32'd0);

        // Streaming after release with decode always ready.
        repeat (2) next_cycle();
        out_ready = 1'b1;
        res       = 1'b0;
        sample();
        check("a_req0", 32'(imem_req), 32'd1);
        check("a_addr0", imem_addr, 32'h40);
        next_cycle(); sample();
        check("a_addr1", imem_addr, 32'h44);
        next_cycle(); sample();
        check("a_valid", 32'(out_valid), 32'd1);
        check("a_out_pc0", out_pc, 32'h40);
        check("a_out_instr0", out_instr, 32'h40 ^ KEY);
        next_cycle(); sample();
        check("a_out_pc1", out_pc, 32'h44);
        next_cycle(); sample();
        check("a_out_pc2", out_pc, 32'h48);
        repeat (40) begin
            next_cycle();
            out_ready = ($urandom_range(0, 3) != 0);
        end

        // Backpressure fills the queue, then drains without loss.
        do_reset(1'b0);
        repeat (8) next_cycle();
        sample();
        check("b_req_stalled", 32'(imem_req), 32'd0);
        check("b_count_full", 32'(count), 32'd4);
        check("b_pc_out", pc_out, 32'h50);
        check("b_out_pc", out_pc, 32'h40);
        check("b_req_total", 32'(req_seen), 32'd4);
        next_cycle();
        out_ready = 1'b1;
        next_cycle(); sample();
        check("b_resume_req", 32'(imem_req), 32'd1);
        check("b_resume_addr", imem_addr, 32'h50);
        check("b_out_pc_next", out_pc, 32'h44);
        repeat (12) next_cycle();

        // Redirect with 0x48 in flight and two entries queued.
        do_reset(1'b0);
        repeat (3) next_cycle();
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        sample();
        check("c_count_before", 32'(count), 32'd2);
        check("c_req_blocked", 32'(imem_req), 32'd0);
        next_cycle();
        redirect = 1'b0;
        sample();
        check("c_count_flushed", 32'(count), 32'd0);
        check("c_addr", imem_addr, 32'h100);
        check("c_req", 32'(imem_req), 32'd1);
        next_cycle();
        next_cycle(); sample();
        check("c_valid", 32'(out_valid), 32'd1);
        check("c_out_pc", out_pc, 32'h100);
        next_cycle();
        out_ready = 1'b1;
        sample();
        check("c_out_pc_hold", out_pc, 32'h100);
        next_cycle(); sample();
        check("c_out_pc_next", out_pc, 32'h104);

        // Address wrap at the top of the address space.
        next_cycle();
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        next_cycle();
        redirect = 1'b0;
        sample();
        check("d_addr_top", imem_addr, 32'hFFFF_FFFC);
        next_cycle(); sample();
        check("d_addr_wrap", imem_addr, 32'h0);
        check("d_req_wrap", 32'(imem_req), 32'd1);
        next_cycle(); sample();
        check("d_out_pc_top", out_pc, 32'hFFFF_FFFC);
        next_cycle(); sample();
        check("d_out_pc_wrap", out_pc, 32'h0);

        // Full queue released: settles to one push and one pop per cycle.
        do_reset(1'b0);
        repeat (8) next_cycle();
        sample();
        check("e_count_full", 32'(count), 32'd4);
        next_cycle();
        out_ready = 1'b1;
        repeat (6) next_cycle();
        for (int i = 0; i < 8; i++) begin
            sample();
            check("e_req_steady", 32'(imem_req), 32'd1);
            check("e_count_steady", 32'(count), 32'd2);
            next_cycle();
        end

        // Reset asserted between clock edges while three entries are queued.
        do_reset(1'b0);
        repeat (4) next_cycle();
        sample();
        check("f_count_pre", 32'(count), 32'd3);
        #1 res = 1'b1;
        #1;
        check("f_count", 32'(count), 32'd0);
        check("f_pc_out", pc_out, 32'h40);
        check("f_valid", 32'(out_valid), 32'd0);
        check("f_req", 32'(imem_req), 32'd0);
        check("f_out_pc", out_pc, 32'd0);
        next_cycle();
        next_cycle();
        res = 1'b0;
        sample();
        check("f_first_req", 32'(imem_req), 32'd1);
        check("f_first_addr", imem_addr, 32'h40);

        // Random traffic: ready jitter and occasional (sometimes repeated) redirects.
        out_ready = 1'b1;
        repeat (300) begin
            next_cycle();
            rnd         = $urandom;
            out_ready   = ($urandom_range(0, 3) != 0);
            redirect    = ($urandom_range(0, 19) == 0);
            redirect_pc = {rnd[31:2], 2'b00};
        end
        next_cycle();
        redirect = 1'b0;
        repeat (10) next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
